// File: rtl/sz_fx_filter.sv
// sz_fx_filter: filters each accepted reference sample through the identified secondary path sz[k]
// using a private circular delay line, a 1-cycle-latency sz_ram read port and a single MAC.
module sz_fx_filter #(
    parameter int TAPS      = 128,
    parameter int OUT_SHIFT = 19,
    parameter int ACC_W     = 43
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               OFZ_ok,
    input  logic               audio_rx_down,
    input  logic signed [15:0] xn,
    output logic [6:0]         sz_rd_addr,
    input  logic signed [19:0] sz,
    output logic signed [15:0] xf,
    output logic               xf_valid,
    output logic               busy,
    output logic               overrun
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-32768);

    state_t                  state_q, state_d;
    logic [6:0]              k_q, k_d, wp_q, wp_d, idx;
    logic [7:0]              fill_q, fill_d;
    logic                    drain_q, drain_d, v_q, ok_q, xf_valid_q, overrun_q, xf_upd;
    logic signed [15:0]      x_q, dx_q, xf_q, xf_d;
    logic signed [15:0]      mem [128];
    logic signed [35:0]      prod;
    logic signed [ACC_W-1:0] prod_q, acc_q, acc_d, acc_sh;

    assign sz_rd_addr = k_q;
    assign xf         = xf_q;
    assign xf_valid   = xf_valid_q;
    assign busy       = state_q != IDLE;
    assign overrun    = overrun_q;
    assign idx        = wp_q - k_q + ((wp_q >= k_q) ? 7'd0 : 7'(TAPS));
    assign prod       = dx_q * sz;
    assign acc_d      = (state_q == LOAD) ? '0 : acc_q + prod_q;
    assign acc_sh     = acc_d >>> OUT_SHIFT;
    assign xf_upd     = state_q == DRAIN && drain_q;
    assign xf_d       = !xf_upd ? xf_q : (acc_sh > MAXV) ? 16'sh7FFF : (acc_sh < MINV) ? 16'sh8000 : acc_sh[15:0];

    always_comb begin
        state_d = state_q;
        k_d     = 7'd0;
        wp_d    = wp_q;
        fill_d  = fill_q;
        drain_d = 1'b0;
        case (state_q)
            IDLE:    if (audio_rx_down && OFZ_ok) state_d = LOAD;
            LOAD: begin
                state_d = RUN;
                fill_d  = (fill_q == 8'(TAPS)) ? fill_q : fill_q + 8'd1;
            end
            RUN:     if (k_q == 7'(TAPS - 1)) state_d = DRAIN; else k_d = k_q + 7'd1;
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                wp_d    = (wp_q == 7'(TAPS - 1)) ? 7'd0 : wp_q + 7'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Delay line: written once per sample, read one tap per RUN cycle to align with sz.
    always_ff @(posedge clk) begin
        if (state_q == IDLE) x_q <= xn;
        if (state_q == LOAD) mem[wp_q] <= x_q;
        dx_q <= mem[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= 7'd0;
            wp_q       <= 7'd0;
            fill_q     <= 8'd0;
            drain_q    <= 1'b0;
            v_q        <= 1'b0;
            ok_q       <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            xf_q       <= 16'sd0;
            xf_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            wp_q       <= wp_d;
            fill_q     <= fill_d;
            drain_q    <= drain_d;
            v_q        <= state_q == RUN;
            ok_q       <= {1'b0, k_q} < fill_q;
            // Taps beyond the stored history contribute nothing, hiding stale RAM.
            prod_q     <= (v_q && ok_q) ? {{(ACC_W - 36){prod[35]}}, prod} : '0;
            acc_q      <= acc_d;
            xf_q       <= xf_d;
            xf_valid_q <= xf_upd;
            overrun_q  <= overrun_q | (audio_rx_down && state_q != IDLE);
        end
    end
endmodule

// File: tb/tb_sz_fx_filter.sv
// tb_sz_fx_filter: two filter instances (TAPS=4/shift 0 and defaults) checked every cycle
// against a sample-history model, plus hand-computed xf literals.
module tb_sz_fx_filter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] ofz = 2'b00;
    logic [1:0] stb = 2'b00;
    logic signed [15:0] xn [2];
    logic signed [15:0] xf [2];
    logic [6:0] addr [2];
    logic signed [19:0] szq [2];
    logic signed [19:0] szm [2][128];
    logic busy [2];
    logic xfv [2];
    logic ovr [2];

    always #5 clk = ~clk;

    sz_fx_filter #(.TAPS(4), .OUT_SHIFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .OFZ_ok(ofz[0]), .audio_rx_down(stb[0]), .xn(xn[0]),
        .sz_rd_addr(addr[0]), .sz(szq[0]), .xf(xf[0]), .xf_valid(xfv[0]), .busy(busy[0]), .overrun(ovr[0])
    );

    sz_fx_filter u_b (
        .clk(clk), .rst_n(rst_n), .OFZ_ok(ofz[1]), .audio_rx_down(stb[1]), .xn(xn[1]),
        .sz_rd_addr(addr[1]), .sz(szq[1]), .xf(xf[1]), .xf_valid(xfv[1]), .busy(busy[1]), .overrun(ovr[1])
    );

    always @(posedge clk) begin
        szq[0] <= szm[0][addr[0]];
        szq[1] <= szm[1][addr[1]];
    end

    int n_pass = 0;
    int n_tot = 0;
    int cyc = 0;
    int tp [2] = '{4, 128};
    int sh [2] = '{0, 19};
    bit act [2] = '{0, 0};
    bit ovr_m [2] = '{0, 0};
    int due [2] = '{0, 0};
    int xf_m [2] = '{0, 0};
    int pend [2] = '{0, 0};
    int hist [2][$];
    int lit [2][$];

    task automatic chk(string nm, int i, longint got, longint exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", nm, i, cyc, got, exp);
    endtask

    function automatic int filt(int i);
        longint s = 0;
        for (int k = 0; k < hist[i].size(); k++) s += longint'(szm[i][k]) * longint'(hist[i][k]);
        s = s >>> sh[i];
        return (s > 32767) ? 32767 : (s < -32768) ? -32768 : int'(s);
    endfunction

    // Advance to mid-cycle, fold in the inputs sampled at the last edge, then compare.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                act[i] = 0;
                ovr_m[i] = 0;
                xf_m[i] = 0;
                hist[i].delete();
            end else begin
                if (act[i] && cyc > due[i] + 1) act[i] = 0;
                if (stb[i]) begin
                    if (act[i]) ovr_m[i] = 1;
                    else if (ofz[i]) begin
                        hist[i].push_front(int'(xn[i]));
                        if (hist[i].size() > tp[i]) void'(hist[i].pop_back());
                        pend[i] = filt(i);
                        act[i] = 1;
                        due[i] = cyc + tp[i] + 3;
                    end
                end
                if (act[i] && cyc == due[i]) xf_m[i] = pend[i];
            end
            chk("xf_valid", i, longint'(xfv[i]), longint'(act[i] && cyc == due[i]));
            chk("busy", i, longint'(busy[i]), longint'(act[i] && cyc <= due[i]));
            chk("overrun", i, longint'(ovr[i]), longint'(ovr_m[i]));
            chk("xf", i, longint'(xf[i]), longint'(xf_m[i]));
            if (act[i] && cyc >= due[i] - tp[i] - 2 && cyc <= due[i] - 3)
                chk("sz_rd_addr", i, longint'(addr[i]), longint'(cyc - (due[i] - tp[i] - 2)));
            if (act[i] && cyc == due[i] && lit[i].size() > 0)
                chk("xf_literal", i, longint'(xf[i]), longint'(lit[i].pop_front()));
        end
    endtask

    task automatic wait_n(int n);
        repeat (n) tick();
    endtask

    task automatic strobe(int i, int x, int gap);
        xn[i] = 16'(x);
        stb[i] = 1'b1;
        tick();
        stb[i] = 1'b0;
        wait_n(gap - 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int a;
        int xs [5] = '{1, 0, 0, 0, 0};
        int ls [4] = '{32766, 32767, -1, -32768};
        int bs [4] = '{32767, 32767, -32768, -32768};
        xn[0] = 16'sd0;
        xn[1] = 16'sd0;
        for (int i = 0; i < 2; i++) for (int k = 0; k < 128; k++) szm[i][k] = 20'sd0;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(2);
        // Impulse response of sz={1,2,3,4}
        for (int k = 0; k < 4; k++) szm[0][k] = 20'(k + 1);
        ofz[0] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            lit[0].push_back(n < 4 ? n + 1 : 0);
            strobe(0, xs[n], 20);
        end
        strobe(0, 7, 20);
        strobe(0, -2, 20);
        // Fresh history after reset; stale delay entries must not contribute
        pulse_reset();
        for (int k = 0; k < 4; k++) szm[0][k] = 20'sd5;
        wait_n(2);
        lit[0].push_back(15);
        strobe(0, 3, 20);
        lit[0].push_back(20);
        strobe(0, 1, 20);
        // Gated strobes leave the block idle
        ofz[0] = 1'b0;
        a = int'(addr[0]);
        strobe(0, 11, 12);
        strobe(0, 12, 12);
        chk("addr_static", 0, longint'(addr[0]), longint'(a));
        ofz[0] = 1'b1;
        lit[0].push_back(50);
        strobe(0, 6, 20);
        // Reset during RUN aborts the sample and the history
        xn[0] = 16'sd8;
        stb[0] = 1'b1;
        tick();
        stb[0] = 1'b0;
        tick();
        pulse_reset();
        chk("busy_after_abort", 0, longint'(busy[0]), 0);
        wait_n(15);
        lit[0].push_back(20);
        strobe(0, 4, 20);
        // Full-size instance: saturation on both rails
        szm[1][0] = 20'sh7FFFF;
        szm[1][1] = 20'sh7FFFF;
        ofz[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            lit[1].push_back(ls[n]);
            strobe(1, bs[n], 140);
        end
        // Strobe while busy is dropped and latches overrun until reset
        lit[1].push_back(-32768);
        strobe(1, 0, 10);
        strobe(1, 9, 140);
        chk("overrun_set", 1, longint'(ovr[1]), 1);
        wait_n(20);
        chk("overrun_sticky", 1, longint'(ovr[1]), 1);
        pulse_reset();
        tick();
        chk("overrun_cleared", 1, longint'(ovr[1]), 0);
        chk("literals_left", 0, longint'(lit[0].size()), 0);
        chk("literals_left", 1, longint'(lit[1].size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
